// File: rtl/fast_pulse_pacer_pkg.sv
// fast_pulse_pkg: shared pacer state type, minimum gap constant and timer sizing helper
package fast_pulse_pkg;
  typedef enum logic [1:0] {PACER_IDLE, PACER_EMIT, PACER_GAP} pacer_state_e;
  localparam int MIN_GAP_CYCLES = 2;
  function automatic int gap_tmr_w(input int gap);
    return (gap > 2) ? $clog2(gap) : 1;
  endfunction
endpackage

// File: rtl/fast_pulse_pacer_if.sv
// fast_pulse_pacer_if: event/pulse bundle between the event source and the pacer
//   event_in  : one event per high cycle          ovf_clr  : clears sticky overflow
//   pulse_out : paced single-cycle pulse          pending  : events queued, not yet emitted
//   busy      : pacer active or backlog present   overflow : sticky event-drop flag
interface fast_pulse_pacer_if #(parameter int CNT_W = 4);
  logic             event_in;
  logic             ovf_clr;
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;
  modport master (output event_in, ovf_clr, input pulse_out, pending, busy, overflow);
  modport slave  (input event_in, ovf_clr, output pulse_out, pending, busy, overflow);
endinterface

// File: rtl/fast_pulse_pacer_gap_timer.sv
// pulse_gap_timer: loadable down-counter that holds at zero
//   fast_clk, rst_n : clock, async active-low reset
//   load_i          : load strobe, load_val_i taken next edge
//   load_val_i      : start value
//   done_o          : count is zero
module pulse_gap_timer #(
  parameter int W = 3
) (
  input  logic         fast_clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge fast_clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/fast_pulse_pacer.sv
// fast_pulse_pacer: queues fast-domain event pulses and re-emits them at least GAP_CYCLES apart
//   fast_clk, rst_n : clock, async active-low reset
//   bus (slave)     : event_in/ovf_clr in; pulse_out/pending/busy/overflow out, all registered
module fast_pulse_pacer
  import fast_pulse_pkg::*;
#(
  parameter int GAP_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic                fast_clk,
  input  logic                rst_n,
  fast_pulse_pacer_if.slave   bus
);
  localparam int TMR_W = gap_tmr_w(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  if (GAP_CYCLES < MIN_GAP_CYCLES || CNT_W < 1) begin : g_param_check
    $error("fast_pulse_pacer: GAP_CYCLES must be >= 2 and CNT_W >= 1");
  end
  pacer_state_e     state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d, pulse_q, busy_q;
  logic             emit, want, drop, tmr_done;
  assign emit = state_q == PACER_EMIT;
  always_comb begin
    want       = pending_q != '0 || bus.event_in;
    // IDLE and an expired GAP both decide between another pulse and going idle
    state_d    = emit ? PACER_GAP :
                 (state_q == PACER_IDLE || tmr_done) ? (want ? PACER_EMIT : PACER_IDLE) : state_q;
    // an emit frees a slot, so an event arriving at saturation during EMIT is still accepted
    drop       = bus.event_in && pending_q == CNT_MAX && !emit;
    pending_d  = drop ? pending_q : pending_q + CNT_W'(bus.event_in) - CNT_W'(emit);
    overflow_d = drop || (overflow_q && !bus.ovf_clr);
  end
  always_ff @(posedge fast_clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= PACER_IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pulse_q    <= state_d == PACER_EMIT;
      busy_q     <= state_d != PACER_IDLE || pending_d != '0;
    end
  // loaded during EMIT with GAP_CYCLES-2 so the next EMIT lands exactly GAP_CYCLES later
  pulse_gap_timer #(.W(TMR_W)) u_gap_timer (
    .fast_clk  (fast_clk),
    .rst_n     (rst_n),
    .load_i    (emit),
    .load_val_i(TMR_W'(GAP_CYCLES - 2)),
    .done_o    (tmr_done)
  );
  assign bus.pulse_out = pulse_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fast_pulse_pacer.sv
// tb_fast_pulse_pacer: table-driven and scoreboard checks of fast_pulse_pacer
module tb_fast_pulse_pacer;
  localparam int GAP = 8;
  localparam int MAXP = 15;
  typedef struct {
    int pulse;
    int pend;
    int busy;
    int ovf;
  } exp_t;
  typedef struct {
    int s1, l1, s2, l2, ncyc, exp_np, exp_last, exp_peak, exp_ovfc;
  } vec_t;
  logic fast_clk = 1'b0;
  logic rst_n = 1'b1;
  fast_pulse_pacer_if #(.CNT_W(4)) bus ();
  fast_pulse_pacer #(.GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .fast_clk(fast_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );
  always #5 fast_clk = ~fast_clk;
  exp_t sb[$];
  vec_t vecs[6];
  int n_chk = 0, n_err = 0;
  int cyc, m_pend, m_ovf, m_last, m_pulse;
  int np, lastp, peak, first_ovf;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask
  task automatic push_exp();
    exp_t e;
    e.pulse = m_pulse;
    e.pend  = m_pend;
    e.busy  = (m_pulse != 0 || cyc - m_last < GAP || m_pend != 0) ? 1 : 0;
    e.ovf   = m_ovf;
    sb.push_back(e);
  endtask
  task automatic do_reset();
    @(negedge fast_clk);
    bus.event_in = 1'b1;
    bus.ovf_clr  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_out", int'(bus.pulse_out), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    repeat (3) @(posedge fast_clk);
    @(negedge fast_clk);
    bus.event_in = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    cyc = 0; m_pend = 0; m_ovf = 0; m_last = -100; m_pulse = 0;
    np = 0; lastp = -1000; peak = 0; first_ovf = -1;
    push_exp();
  endtask
  task automatic step(input int ev, input int clr);
    exp_t e;
    int drop;
    @(negedge fast_clk);
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_empty @cycle %0d: got 0 entries, expected 1", cyc);
    end else begin
      e = sb.pop_front();
      chk("pulse_out", int'(bus.pulse_out), e.pulse);
      chk("pending", int'(bus.pending), e.pend);
      chk("busy", int'(bus.busy), e.busy);
      chk("overflow", int'(bus.overflow), e.ovf);
    end
    if (bus.pulse_out) begin
      if (lastp > -1000) begin
        n_chk++;
        if (cyc - lastp < GAP) begin
          n_err++;
          $display("FAIL pulse_spacing @cycle %0d: got %0d cycles, expected >= %0d", cyc, cyc - lastp, GAP);
        end
      end
      np++;
      lastp = cyc;
    end
    if (int'(bus.pending) > peak) peak = int'(bus.pending);
    if (bus.overflow && first_ovf < 0) first_ovf = cyc;
    bus.event_in = ev[0];
    bus.ovf_clr  = clr[0];
    drop   = (ev != 0 && m_pend == MAXP && m_pulse == 0) ? 1 : 0;
    m_pend = drop != 0 ? m_pend : m_pend + ev - m_pulse;
    m_ovf  = (drop != 0 || (m_ovf != 0 && clr == 0)) ? 1 : 0;
    if (m_pulse != 0) m_last = cyc;
    cyc++;
    m_pulse = (m_pend != 0 && cyc - m_last >= GAP) ? 1 : 0;
    push_exp();
  endtask
  initial begin
    int evc;
    bus.event_in = 1'b0;
    bus.ovf_clr  = 1'b0;
    vecs[0] = '{10, 1, 0, 0, 30, 1, 11, 1, -1};
    vecs[1] = '{0, 5, 0, 0, 45, 5, 33, 4, -1};
    vecs[2] = '{0, 20, 0, 0, 150, 18, 137, 15, 19};
    vecs[3] = '{0, 1, 8, 1, 30, 2, 9, 1, -1};
    vecs[4] = '{0, 1, 7, 1, 30, 2, 9, 1, -1};
    vecs[5] = '{0, 1, 9, 1, 30, 2, 10, 1, -1};
    foreach (vecs[k]) begin
      do_reset();
      for (int i = 0; i < vecs[k].ncyc; i++)
        step(((i >= vecs[k].s1 && i < vecs[k].s1 + vecs[k].l1) ||
              (i >= vecs[k].s2 && i < vecs[k].s2 + vecs[k].l2)) ? 1 : 0, 0);
      chk($sformatf("vec%0d_pulse_count", k), np, vecs[k].exp_np);
      chk($sformatf("vec%0d_last_pulse", k), lastp, vecs[k].exp_last);
      chk($sformatf("vec%0d_peak_pending", k), peak, vecs[k].exp_peak);
      chk($sformatf("vec%0d_first_overflow", k), first_ovf, vecs[k].exp_ovfc);
    end
    // reset in the middle of a saturating burst discards the backlog
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 0);
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0);
    chk("post_reset_no_pulse", np, 0);
    evc = cyc;
    step(1, 0);
    step(0, 0);
    chk("post_reset_latency", lastp, evc + 1);
    for (int i = 0; i < 10; i++) step(0, 0);
    // a drop in the same cycle as ovf_clr keeps overflow set
    do_reset();
    for (int i = 0; i < 19; i++) step(1, 0);
    step(1, 1);
    chk("ovf_set_c19", int'(bus.overflow), 1);
    step(0, 1);
    chk("ovf_set_wins_c20", int'(bus.overflow), 1);
    step(0, 0);
    chk("ovf_cleared_c21", int'(bus.overflow), 0);
    for (int i = 0; i < 130; i++) step(0, 0);
    chk("ovf_drain_count", np, 18);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
